// File: rtl/fa_bist_pkg.sv
// fa_bist_pkg: shared FSM state type and default BIST constants for the fulladder BIST.
package fa_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int DEF_N_PAT = 8;
  localparam int DEF_MISR_W = 8;
  localparam logic [7:0] DEF_POLY = 8'h1D;
  localparam logic [7:0] DEF_SEED = 8'h00;
  localparam logic [7:0] DEF_GOLDEN = 8'h47;
endpackage

// File: rtl/fa_bist_ctrl_if.sv
// fa_bist_ctrl_if: pattern, response and status signals between the BIST controller and its environment.
interface fa_bist_ctrl_if import fa_bist_pkg::*; #(parameter int W = DEF_MISR_W);
  logic start, pat_i0, pat_i1, pat_ci, dut_s, dut_co, busy, done, pass;
  logic [W-1:0] signature;
  modport master(output start, dut_s, dut_co, input pat_i0, pat_i1, pat_ci, busy, done, pass, signature);
  modport slave(input start, dut_s, dut_co, output pat_i0, pat_i1, pat_ci, busy, done, pass, signature);
endinterface

// File: rtl/fa_bist_ctrl_misr_reg.sv
// misr_reg: multiple-input signature register compacting a 2-bit response per enabled cycle.
module misr_reg #(
  parameter int W = 8,
  parameter logic [W-1:0] POLY = W'(8'h1D)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] seed,
  input  logic [1:0]   din,
  output logic [W-1:0] sig
);
  always_ff @(posedge clk)
    if (rst || load) sig <= seed;
    else if (en) sig <= (sig << 1) ^ (sig[W-1] ? POLY : '0) ^ {{(W-2){1'b0}}, din};
endmodule

// File: rtl/fa_bist_ctrl.sv
// fa_bist_ctrl: exhaustive-pattern BIST controller for the fulladder with MISR compaction and golden compare.
module fa_bist_ctrl import fa_bist_pkg::*; #(
  parameter int N_PAT = DEF_N_PAT,
  parameter int MISR_W = DEF_MISR_W,
  parameter logic [MISR_W-1:0] POLY = MISR_W'(DEF_POLY),
  parameter logic [MISR_W-1:0] SEED = MISR_W'(DEF_SEED),
  parameter logic [MISR_W-1:0] GOLDEN = MISR_W'(DEF_GOLDEN)
) (
  input logic clk,
  input logic rst,
  fa_bist_ctrl_if.slave bus
);
  localparam int CW = $clog2(N_PAT) + 1;
  state_t state;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] pat;
  logic [MISR_W-1:0] sig;
  logic accept, busy, done;
  assign cnt_nx = cnt + 1'b1;
  assign accept = (state == IDLE || state == DONE) && bus.start;
  misr_reg #(.W(MISR_W), .POLY(POLY)) u_misr (
    .clk(clk), .rst(rst), .load(accept), .en(state == RUN || state == DRAIN),
    .seed(SEED), .din({bus.dut_co, bus.dut_s}), .sig(sig)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pat <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state <= (N_PAT == 1) ? DRAIN : RUN;
          cnt <= '0;
          pat <= '0;
          busy <= 1'b1;
          done <= 1'b0;
        end
        RUN: begin
          cnt <= cnt_nx;
          pat <= 3'(cnt_nx);
          if (cnt_nx == CW'(N_PAT - 1)) state <= DRAIN;
        end
        DRAIN: begin
          pat <= '0;
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  assign {bus.pat_i0, bus.pat_i1, bus.pat_ci} = pat;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.pass = done && (sig == GOLDEN);
  assign bus.signature = sig;
endmodule

// File: tb/tb_fa_bist_ctrl.sv
// tb_fa_bist_ctrl: directed table-driven checks of the fulladder BIST controller with a fault-injectable adder model.
module tb_fa_bist_ctrl;
  typedef struct {
    logic [2:0] pat;
    logic [7:0] sig;
    logic [7:0] sig_sa0;
    logic busy, done, pass;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, sa0 = 1'b0;
  int tests = 0, fails = 0;
  vec_t tbl[9];
  fa_bist_ctrl_if #(.W(8)) bus();
  fa_bist_ctrl dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.dut_s = sa0 ? 1'b0 : (bus.pat_i0 ^ bus.pat_i1 ^ bus.pat_ci);
  assign bus.dut_co = (bus.pat_i0 & bus.pat_i1) | (bus.pat_ci & (bus.pat_i0 ^ bus.pat_i1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " pat"}, {bus.pat_i0, bus.pat_i1, bus.pat_ci}, 0);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " done"}, bus.done, 0);
    chk({tag, " pass"}, bus.pass, 0);
    chk({tag, " sig"}, bus.signature, 8'h00);
  endtask
  task automatic run(input string tag, input logic [8:0] smask, input logic fault);
    for (int i = 0; i < 9; i++) begin
      bus.start = smask[i];
      tick();
      bus.start = 1'b0;
      chk($sformatf("%s[%0d] pat", tag, i), {bus.pat_i0, bus.pat_i1, bus.pat_ci}, tbl[i].pat);
      chk($sformatf("%s[%0d] sig", tag, i), bus.signature, fault ? tbl[i].sig_sa0 : tbl[i].sig);
      chk($sformatf("%s[%0d] busy", tag, i), bus.busy, tbl[i].busy);
      chk($sformatf("%s[%0d] done", tag, i), bus.done, tbl[i].done);
      chk($sformatf("%s[%0d] pass", tag, i), bus.pass, fault ? 1'b0 : tbl[i].pass);
    end
  endtask
  initial begin
    logic [7:0] s[9] = '{8'h00, 8'h00, 8'h01, 8'h03, 8'h04, 8'h09, 8'h10, 8'h22, 8'h47};
    logic [7:0] f[9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h04, 8'h0A, 8'h16, 8'h2E};
    for (int i = 0; i < 9; i++)
      tbl[i] = '{pat: (i < 8) ? 3'(i) : 3'd0, sig: s[i], sig_sa0: f[i],
                 busy: i < 8, done: i == 8, pass: i == 8};
    bus.start = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("idle");
    run("clean", 9'b0_0000_0001, 1'b0);
    tick();
    tick();
    chk("done hold", bus.done, 1);
    chk("sig frozen", bus.signature, 8'h47);
    run("redo", 9'b0_0000_0001, 1'b0);
    sa0 = 1'b1;
    run("s_sa0", 9'b0_0000_0001, 1'b1);
    sa0 = 1'b0;
    run("restart", 9'b1_1000_1011, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre-rst busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mid rst");
    tick();
    chk_idle("mid rst hold");
    run("after rst", 9'b0_0000_0001, 1'b0);
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    chk_idle("rst+start");
    tick();
    chk_idle("rst+start hold");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
